// File: rtl/stream_argmax_if.sv
// Handshake bundle for stream_argmax: score beats in, winning value/index out.
interface stream_argmax_if #(
    parameter int BIT_WIDTH   = 8,
    parameter int INDEX_WIDTH = 4
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [BIT_WIDTH-1:0]   in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [BIT_WIDTH-1:0]   out_val;
    logic [INDEX_WIDTH-1:0]        out_idx;
    logic                          busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_val, out_idx, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_val, out_idx, busy
    );
endinterface

// File: rtl/stream_argmax.sv
// Streaming argmax: tracks the running signed maximum of NUM_INPUTS beats and
// presents the winning value and arrival index on a valid/ready result port.
module stream_argmax #(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_INPUTS  = 10,
    parameter int INDEX_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    stream_argmax_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_INPUTS - 1);
    localparam logic [INDEX_WIDTH-1:0] ONE_IDX  = INDEX_WIDTH'(1);
    localparam logic [INDEX_WIDTH-1:0] ZERO_IDX = {INDEX_WIDTH{1'b0}};
    localparam logic [BIT_WIDTH-1:0]   ZERO_VAL = {BIT_WIDTH{1'b0}};

    state_t                      state_r;
    logic [INDEX_WIDTH-1:0]      count_r;
    logic signed [BIT_WIDTH-1:0] best_val_r;
    logic [INDEX_WIDTH-1:0]      best_idx_r;
    logic signed [BIT_WIDTH-1:0] out_val_r;
    logic [INDEX_WIDTH-1:0]      out_idx_r;
    logic                        out_valid_r;
    logic                        in_ready_r;
    logic                        busy_r;

    logic                        accept_s;
    logic signed [BIT_WIDTH-1:0] win_val_s;
    logic [INDEX_WIDTH-1:0]      win_idx_s;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_val   = out_val_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.busy      = busy_r;

    // Pairwise compare of current best against the incoming score; ties go to the newer beat.
    always_comb begin
        accept_s  = bus.in_valid && in_ready_r;
        win_val_s = best_val_r;
        win_idx_s = best_idx_r;
        if (best_val_r > $signed(bus.in_data)) begin
            win_val_s = best_val_r;
            win_idx_s = best_idx_r;
        end else begin
            win_val_s = $signed(bus.in_data);
            win_idx_s = count_r;
        end
    end

    // Vector FSM: first beat seeds the best, later beats compare, last beat publishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            count_r     <= ZERO_IDX;
            best_val_r  <= ZERO_VAL;
            best_idx_r  <= ZERO_IDX;
            out_val_r   <= ZERO_VAL;
            out_idx_r   <= ZERO_IDX;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        best_val_r <= $signed(bus.in_data);
                        best_idx_r <= ZERO_IDX;
                        count_r    <= ONE_IDX;
                        busy_r     <= 1'b1;
                        state_r    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        best_val_r <= win_val_s;
                        best_idx_r <= win_idx_s;
                        // Count saturates at the last index so it never wraps within a vector.
                        if (count_r == LAST_IDX) begin
                            out_val_r   <= win_val_s;
                            out_idx_r   <= win_idx_s;
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                            state_r     <= DONE;
                        end else begin
                            count_r <= count_r + ONE_IDX;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        count_r     <= ZERO_IDX;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    count_r     <= ZERO_IDX;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stream_argmax.sv
// Directed bench for stream_argmax: vector table plus hold, reset-flush and N=2 sequences.
module tb_stream_argmax;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stream_argmax_if #(.BIT_WIDTH(8), .INDEX_WIDTH(4)) bus  ();
    stream_argmax_if #(.BIT_WIDTH(8), .INDEX_WIDTH(2)) bus2 ();

    stream_argmax #(.BIT_WIDTH(8), .NUM_INPUTS(10), .INDEX_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    stream_argmax #(.BIT_WIDTH(8), .NUM_INPUTS(2), .INDEX_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    typedef struct {
        logic [9:0][7:0] scores;
        logic [7:0]      exp_val;
        logic [3:0]      exp_idx;
        bit              gaps;
    } vec_t;

    vec_t tab [6];

    function automatic logic [9:0][7:0] mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
        logic [9:0][7:0] r;
        r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3); r[4] = 8'(a4);
        r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7); r[8] = 8'(a8); r[9] = 8'(a9);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [7:0] v);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hxx;
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({name, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        check({name, "_busy_drop"},  {31'd0, bus.busy},      32'd0);
        check({name, "_in_ready"},   {31'd0, bus.in_ready},  32'd1);
    endtask

    // Streams one table vector; result is checked immediately after the last accept.
    task automatic run_vec(input int k);
        for (int j = 0; j < 10; j++) begin
            if (tab[k].gaps) repeat ($urandom_range(2, 0)) @(negedge clk);
            if (j == 9) check($sformatf("v%0d_early_valid", k), {31'd0, bus.out_valid}, 32'd0);
            beat(tab[k].scores[j]);
            if (j == 0) check($sformatf("v%0d_busy", k), {31'd0, bus.busy}, 32'd1);
        end
        check($sformatf("v%0d_valid", k), {31'd0, bus.out_valid}, 32'd1);
        check($sformatf("v%0d_val", k),   {24'd0, bus.out_val},   {24'd0, tab[k].exp_val});
        check($sformatf("v%0d_idx", k),   {28'd0, bus.out_idx},   {28'd0, tab[k].exp_idx});
    endtask

    task automatic run2(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ev, input logic [1:0] ei);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1;
            bus2.in_data  = (j == 0) ? a : b;
            @(posedge clk);
            #1;
            bus2.in_valid = 1'b0;
        end
        check({name, "_valid"}, {31'd0, bus2.out_valid}, 32'd1);
        check({name, "_val"},   {24'd0, bus2.out_val},   {24'd0, ev});
        check({name, "_idx"},   {30'd0, bus2.out_idx},   {30'd0, ei});
        @(negedge clk);
        bus2.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus2.out_ready = 1'b0;
        check({name, "_drop"}, {31'd0, bus2.out_valid}, 32'd0);
    endtask

    initial begin
        tab[0] = '{mk(3, -5, 7, 2, 7, 0, -1, 6, 1, 4), 8'd7, 4'd4, 1'b0};
        // 8'h80 is -128
        tab[1] = '{mk(-128, -128, -128, -128, -128, -128, -128, -128, -128, -128), 8'h80, 4'd9, 1'b0};
        tab[2] = '{mk(127, -1, -1, -1, -1, -1, -1, -1, -1, -1), 8'd127, 4'd0, 1'b0};
        tab[3] = '{mk(3, -5, 7, 2, 7, 0, -1, 6, 1, 4), 8'd7, 4'd4, 1'b1};
        tab[4] = '{mk(5, 9, -128, 9, 8, 0, 0, 0, 0, 9), 8'd9, 4'd9, 1'b1};
        tab[5] = '{mk(9, 8, 7, 6, 5, 4, 3, 2, 1, 0), 8'd9, 4'd0, 1'b0};

        rst_n = 1'b0;
        bus.in_valid = 1'b0;  bus.in_data = 8'h00;  bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = 8'h00; bus2.out_ready = 1'b0;
        #3;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_val",   {24'd0, bus.out_val},   32'd0);
        check("rst_out_idx",   {28'd0, bus.out_idx},   32'd0);
        check("rst_busy",      {31'd0, bus.busy},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int k = 0; k < 5; k++) begin
            run_vec(k);
            handshake($sformatf("v%0d_hs", k));
        end

        // Hold result under backpressure while pulsing in_valid with a larger score.
        run_vec(0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.in_valid = c[0];
            bus.in_data  = 8'd100;
            check($sformatf("hold%0d", c),
                  {18'd0, bus.out_valid, bus.in_ready, bus.out_idx, bus.out_val},
                  {18'd0, 1'b1, 1'b0, 4'd4, 8'd7});
        end
        bus.in_valid = 1'b0;
        handshake("hold_hs");
        run_vec(5);
        handshake("b2b_hs");

        // Flush mid-vector.
        for (int j = 0; j < 5; j++) beat(tab[2].scores[j]);
        #2;
        rst_n = 1'b0;
        #1;
        check("flush_mid_busy",  {31'd0, bus.busy},      32'd0);
        check("flush_mid_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0);
        // Flush while the result is pending.
        #2;
        rst_n = 1'b0;
        #1;
        check("flush_done_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush_done_busy",  {31'd0, bus.busy},      32'd0);
        check("flush_done_val",   {24'd0, bus.out_val},   32'd0);
        check("flush_done_idx",   {28'd0, bus.out_idx},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(2);
        handshake("post_flush_hs");

        run2("n2_a", 8'hff, 8'h00, 8'h00, 2'd1);
        run2("n2_b", 8'h00, 8'hff, 8'h00, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_argmax.md
Name: stream_argmax

Overview:
- Sequential, streaming counterpart of the combinational pairwise max/index comparator.
- Consumes a vector of NUM_INPUTS signed scores, one per accepted beat, tagging each with its arrival index, and keeps a running maximum.
- After the last beat it presents the winning value and index on a valid/ready output port.
- Sits at the classifier output: the serial score stream enters here and the class decision leaves.

Parameters:
- BIT_WIDTH, 8, width of each signed score.
- NUM_INPUTS, 10, scores per vector (2..2^INDEX_WIDTH−1 legal).
- INDEX_WIDTH, 4, width of the index and element counter; must satisfy 2^INDEX_WIDTH > NUM_INPUTS.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  score beat valid.
- in_ready  out  1  block can accept a score.
- in_data  in  BIT_WIDTH  signed score.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_val  out  BIT_WIDTH  signed maximum score.
- out_idx  out  INDEX_WIDTH  index (0-based arrival order) of the maximum.
- busy  out  1  at least one beat of the current vector has been accepted and the result is not yet delivered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; count=0; best_val=0; best_idx=0.
  - Outputs: out_valid=0, out_val=0, out_idx=0, busy=0, in_ready=1 (once rst_n high).
- Accept event: a beat is accepted on a clock edge with in_valid&&in_ready. Result delivered on out_valid&&out_ready.
- IDLE:
  - in_ready=1, busy=0.
  - On accept: best_val<=in_data, best_idx<=0, count<=1, go to ACCUM.
  - If NUM_INPUTS==1 would apply, the block still requires ≥2 (parameter rule).
- ACCUM:
  - in_ready=1, busy=1.
  - On accept: if best_val > in_data (signed, strict), keep best; else best_val<=in_data, best_idx<=count.
  - Ties therefore select the later index, identical to the pairwise comparator with in1=current best, in2=new score.
  - count<=count+1.
  - When the accepted beat has count==NUM_INPUTS−1, load out_val/out_idx with the post-compare winner, set out_valid=1, go to DONE on that same edge.
  - Latency: out_valid rises on the cycle after the last beat is accepted.
  - Without in_valid, state holds indefinitely; no timeout.
- DONE:
  - in_ready=0 (backpressure; no beats of the next vector are accepted). busy=1.
  - out_val/out_idx/out_valid are stable until the handshake.
  - On out_ready: out_valid<=0, count<=0, go to IDLE.
  - in_ready returns to 1 the cycle after the handshake. The first beat of the next vector cannot be taken in the handshake cycle, so one bubble per vector is accepted behaviour.
- out_val/out_idx are registered and hold their last value after delivery until the next result; only out_valid qualifies them.
- Signed compare uses full BIT_WIDTH two's complement: −128 < −1 < 0 < 127. No saturation or widening.
- count never exceeds NUM_INPUTS−1 and never wraps within a vector.
- Asynchronous reset mid-vector or during DONE discards the partial or pending result immediately (out_valid drops without a handshake). Downstream treats this as a flush.
- in_data is don't-care when in_valid=0. X on in_data with in_valid=0 must not propagate to state.

Test Plan:
- Scores [3,−5,7,2,7,0,−1,6,1,4], NUM_INPUTS=10 -> out_val=7, out_idx=4 (tie goes to later index); out_valid exactly one cycle after 10th accept.
- All scores −128 -> out_val=−128, out_idx=9. Scores 127 at index 0, rest −1 -> out_val=127, out_idx=0.
- Random in_valid gaps (~50% duty) with the same vector as scenario 1 -> identical result; count advances only on accepted beats.
- Hold out_ready=0 for 20 cycles after result -> out_valid, out_val, out_idx stable; in_ready=0; in_valid pulses ignored. Release -> IDLE, in_ready=1 next cycle; a back-to-back second vector produces the correct second result.
- Assert rst_n low after 5 beats, and separately while in DONE -> outputs and busy go to 0 asynchronously. A full new vector afterwards yields the correct independent result.
- Vector [−1,0] with NUM_INPUTS=2 -> out_val=0, out_idx=1; [0,−1] -> out_val=0, out_idx=0.
